// File: rtl/sha3_pkg.sv
// Shared SHA3 definitions used by the absorb unit, the round core and the
// squeeze unit.
//   LANE_W          : width of one Keccak lane (64 bits)
//   STATE_W         : width of the full Keccak state (1600 bits)
//   squeeze_state_t : FSM encoding of the squeeze unit
//   lane()          : extracts lane (x, y) from a packed state,
//                     with lane index i = x + 5*y at bits [64*i +: 64]
package sha3_pkg;

  localparam int LANE_W  = 64;
  localparam int STATE_W = 1600;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } squeeze_state_t;

  function automatic logic [LANE_W-1:0] lane(
    input logic [STATE_W-1:0] state,
    input int                 x,
    input int                 y
  );
    return state[LANE_W*(x + 5*y) +: LANE_W];
  endfunction

endpackage

// File: rtl/sha3_squeeze.sv
// SHA3 sponge output stage. Captures the permuted Keccak state after the final
// round and streams its first OUT_LANES lanes as 64-bit words over a
// valid/ready handshake. The last word is flagged with DOUT_LAST.
// Ports:
//   CLK, RST_N            : clock (rising edge), asynchronous active-low reset
//   STATE_IN              : 1600-bit Keccak state, lane i at [64*i +: 64]
//   STATE_VALID/READY     : state capture handshake (ready only when IDLE)
//   ABORT                 : synchronous flush of the digest in flight
//   DOUT                  : current digest lane (registered, unmodified lane)
//   DOUT_VALID/READY      : digest word handshake
//   DOUT_LAST             : DOUT is lane OUT_LANES-1
module sha3_squeeze
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [STATE_W-1:0] STATE_IN,
  input  logic               STATE_VALID,
  output logic               STATE_READY,
  input  logic               ABORT,
  output logic [LANE_W-1:0]  DOUT,
  output logic               DOUT_VALID,
  input  logic               DOUT_READY,
  output logic               DOUT_LAST
);

  generate
    if (OUT_LANES < 1 || OUT_LANES > RATE_LANES) begin : g_bad_out_lanes
      $error("sha3_squeeze: OUT_LANES must be in 1..RATE_LANES");
    end
  endgenerate

  localparam int                CNT_W    = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OUT_LANES - 1);

  squeeze_state_t                state_reg, state_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [LANE_W-1:0]             dout_reg;
  logic [OUT_LANES*LANE_W-1:0]   buf_reg;
  logic [OUT_LANES*LANE_W-1:0]   cap_vec;
  logic                          load_first;
  logic                          load_next;
  logic                          beat;

  // Gather the digest lanes from the state in output order.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_LANES; gi++) begin : g_cap
      assign cap_vec[gi*LANE_W +: LANE_W] = lane(STATE_IN, gi % 5, gi / 5);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_first = 1'b0;
    load_next  = 1'b0;
    beat       = (state_reg == SEND) && DOUT_READY;
    case (state_reg)
      IDLE: begin
        // ABORT suppresses a capture in the same cycle.
        if (!ABORT && STATE_VALID) begin
          state_next = SEND;
          cnt_next   = '0;
          load_first = 1'b1;
        end
      end
      SEND: begin
        if (ABORT) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (beat) begin
          if (cnt_reg == LAST_CNT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next  = cnt_reg + 1'b1;
            load_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The buffer only holds data while SEND is active, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (load_first) begin
      buf_reg <= cap_vec;
    end
  end

  // Lane 0 comes straight from STATE_IN so it is ready one cycle after capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_reg <= '0;
    end else if (load_first) begin
      dout_reg <= lane(STATE_IN, 0, 0);
    end else if (load_next) begin
      dout_reg <= buf_reg[LANE_W*int'(cnt_next) +: LANE_W];
    end
  end

  assign DOUT        = dout_reg;
  assign DOUT_VALID  = (state_reg == SEND);
  assign DOUT_LAST   = (state_reg == SEND) && (cnt_reg == LAST_CNT);
  assign STATE_READY = (state_reg == IDLE);

endmodule

// File: tb/tb_sha3_squeeze.sv
module tb_sha3_squeeze;
  import sha3_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [STATE_W-1:0] state_in;
  logic               state_valid;
  logic               state_ready;
  logic               abort;
  logic [LANE_W-1:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;

  // Single-lane instance with its own handshake signals.
  logic               state_valid1;
  logic               state_ready1;
  logic               abort1;
  logic [LANE_W-1:0]  dout1;
  logic               dout_valid1;
  logic               dout_ready1;
  logic               dout_last1;

  int n_vec;
  int n_miss;

  sha3_squeeze #(.RATE_LANES(17), .OUT_LANES(4)) dut (
    .CLK(clk), .RST_N(rst_n), .STATE_IN(state_in), .STATE_VALID(state_valid),
    .STATE_READY(state_ready), .ABORT(abort), .DOUT(dout), .DOUT_VALID(dout_valid),
    .DOUT_READY(dout_ready), .DOUT_LAST(dout_last)
  );

  sha3_squeeze #(.RATE_LANES(17), .OUT_LANES(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .STATE_IN(state_in), .STATE_VALID(state_valid1),
    .STATE_READY(state_ready1), .ABORT(abort1), .DOUT(dout1), .DOUT_VALID(dout_valid1),
    .DOUT_READY(dout_ready1), .DOUT_LAST(dout_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // State with lane i = base + i.
  function automatic logic [STATE_W-1:0] mk_state(input logic [63:0] base);
    logic [STATE_W-1:0] s;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = base + 64'(i);
    return s;
  endfunction

  logic [63:0] empty_dig [4];
  logic        rdy_pat [7];

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    empty_dig[0] = 64'h66d71ebff8c6ffa7;
    empty_dig[1] = 64'h62d661a05647c151;
    empty_dig[2] = 64'hfa493be44dff80f5;
    empty_dig[3] = 64'h4a43f8804b0ad882;
    rdy_pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n        = 1'b0;
    state_in     = '0;
    state_valid  = 1'b0;
    abort        = 1'b0;
    dout_ready   = 1'b0;
    state_valid1 = 1'b0;
    abort1       = 1'b0;
    dout_ready1  = 1'b0;
    #1;
    chk("rst_dout", dout, 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);
    chk("rst_last", 64'(dout_last), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(state_ready), 64'h1);
    chk("rst_ready1", 64'(state_ready1), 64'h1);

    // ---- Empty-message digest ----
    state_in = mk_state(64'h5a5a_0000_0000_0000);
    for (int i = 0; i < 4; i++) state_in[64*i +: 64] = empty_dig[i];
    state_valid = 1'b1;
    dout_ready  = 1'b1;
    tick();
    state_valid = 1'b0;
    state_in    = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("empty_valid%0d", k), 64'(dout_valid), 64'h1);
      chk($sformatf("empty_dout%0d", k), dout, empty_dig[k]);
      chk($sformatf("empty_last%0d", k), 64'(dout_last), 64'(k == 3));
      chk($sformatf("empty_sready%0d", k), 64'(state_ready), 64'h0);
      tick();
    end
    chk("empty_end_valid", 64'(dout_valid), 64'h0);
    chk("empty_end_sready", 64'(state_ready), 64'h1);

    // ---- Backpressure ----
    state_in    = mk_state(64'h1);
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 7; c++) begin
        dout_ready = rdy_pat[c];
        chk($sformatf("bp_valid%0d", c), 64'(dout_valid), 64'h1);
        chk($sformatf("bp_dout%0d", c), dout, 64'(idx + 1));
        chk($sformatf("bp_last%0d", c), 64'(dout_last), 64'(idx == 3));
        tick();
        if (rdy_pat[c]) idx++;
      end
    end
    chk("bp_end_valid", 64'(dout_valid), 64'h0);
    chk("bp_end_sready", 64'(state_ready), 64'h1);

    // ---- Capture isolation ----
    dout_ready  = 1'b1;
    state_in    = mk_state(64'h100);
    state_valid = 1'b1;
    tick();
    state_in = '1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("iso_dout%0d", k), dout, 64'h100 + 64'(k));
      chk($sformatf("iso_sready%0d", k), 64'(state_ready), 64'h0);
      tick();
    end
    // IDLE re-entered with STATE_VALID still high: capture happens now.
    chk("iso_idle_valid", 64'(dout_valid), 64'h0);
    chk("iso_idle_sready", 64'(state_ready), 64'h1);
    tick();
    state_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("iso2_valid%0d", k), 64'(dout_valid), 64'h1);
      chk($sformatf("iso2_dout%0d", k), dout, 64'hffff_ffff_ffff_ffff);
      tick();
    end
    chk("iso2_end_valid", 64'(dout_valid), 64'h0);

    // ---- Abort during beat 2 ----
    state_in    = mk_state(64'h1);
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    chk("ab_dout0", dout, 64'h1);
    tick();
    chk("ab_dout1", dout, 64'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 64'(dout_valid), 64'h0);
    chk("ab_last", 64'(dout_last), 64'h0);
    chk("ab_sready", 64'(state_ready), 64'h1);
    state_in    = mk_state(64'ha0);
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ab_new_dout%0d", k), dout, 64'ha0 + 64'(k));
      tick();
    end
    chk("ab_new_end_valid", 64'(dout_valid), 64'h0);

    // ---- Reset mid-stream ----
    state_in    = mk_state(64'h1);
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    tick();
    tick();
    chk("rs_pre_dout", dout, 64'h3);
    chk("rs_pre_valid", 64'(dout_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 64'(dout_valid), 64'h0);
    chk("rs_async_last", 64'(dout_last), 64'h0);
    chk("rs_async_dout", dout, 64'h0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rs_post_valid%0d", k), 64'(dout_valid), 64'h0);
      chk($sformatf("rs_post_sready%0d", k), 64'(state_ready), 64'h1);
    end

    // ---- OUT_LANES=1 instance ----
    state_in     = mk_state(64'hdead_beef_0000_0000);
    state_valid1 = 1'b1;
    dout_ready1  = 1'b1;
    tick();
    state_valid1 = 1'b0;
    chk("one_valid", 64'(dout_valid1), 64'h1);
    chk("one_last", 64'(dout_last1), 64'h1);
    chk("one_dout", dout1, 64'hdead_beef_0000_0000);
    chk("one_sready", 64'(state_ready1), 64'h0);
    tick();
    chk("one_end_valid", 64'(dout_valid1), 64'h0);
    chk("one_end_last", 64'(dout_last1), 64'h0);
    chk("one_end_sready", 64'(state_ready1), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sha3_squeeze.md
# sha3_squeeze

Output end of the SHA3 sponge: captures the permuted 1600-bit Keccak state after the final round and streams the first `OUT_LANES` lanes out as 64-bit words over a valid/ready interface, marking the last word. It sits between the round core (theta/rho/pi/chi/iota chain) and the digest consumer, and mirrors the absorb/pad unit on the input side.

## Interface
- `RATE_LANES`, 17: rate in 64-bit lanes (17 for SHA3-256); used only for the elaboration check.
- `OUT_LANES`, 4: digest length in lanes (4 gives 256 bits). Elaboration error if `OUT_LANES` < 1 or `OUT_LANES` > `RATE_LANES`.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `STATE_IN` in 1600: Keccak state. Lane i = `STATE_IN[64*i +: 64]`, with i = x + 5*y.
- `STATE_VALID` in 1: `STATE_IN` holds a finished permutation.
- `STATE_READY` out 1: block can capture a state.
- `ABORT` in 1: synchronous flush of the current digest.
- `DOUT` out 64: current digest lane, registered.
- `DOUT_VALID` out 1: `DOUT` is valid.
- `DOUT_READY` in 1: consumer accepts `DOUT`.
- `DOUT_LAST` out 1: `DOUT` is lane `OUT_LANES`-1.

## Operation
- FSM states: `IDLE`, `SEND`.
- **IDLE**
  - `STATE_READY`=1, `DOUT_VALID`=0.
  - When `STATE_VALID`=1, latch lanes 0..`OUT_LANES`-1 into the internal buffer.
  - Set the lane counter to 0, load `DOUT` with lane 0, go to `SEND`.
- **SEND**
  - `STATE_READY`=0. `STATE_VALID` is ignored and `STATE_IN` may change freely.
  - `DOUT_VALID`=1. `DOUT` and `DOUT_LAST` hold stable until a beat (`DOUT_VALID` & `DOUT_READY`).
  - On a beat with counter < `OUT_LANES`-1: increment the counter and load the next lane.
  - On a beat with counter = `OUT_LANES`-1: go to `IDLE` and clear `DOUT_VALID` and `DOUT_LAST`.
- `DOUT_LAST` = (counter == `OUT_LANES`-1) while in `SEND`. When `OUT_LANES`=1, the first word has `DOUT_LAST`=1.
- Lane words are passed unmodified. Byte 0 of the digest is `DOUT[7:0]` of lane 0 (little-endian lanes).
- **ABORT**
  - In `SEND`: next state is `IDLE`, counter cleared, `DOUT_VALID`=0. Any beat in the same cycle still counts as consumed.
  - In `IDLE`: `ABORT` wins over `STATE_VALID`; no capture happens.
- **Reset** (`RST_N` low): immediate, also mid-stream. State = `IDLE`, counter 0, `DOUT`=0, `DOUT_VALID`=0, `DOUT_LAST`=0, `STATE_READY`=1 once `RST_N` is high. The buffer is not reset.
- The counter width is $clog2(`OUT_LANES`), minimum 1. It never wraps past `OUT_LANES`-1.

## Timing
- Capture edge at cycle t → `DOUT_VALID`=1 with lane 0 at t+1.
- With `DOUT_READY` held high, lane k is presented at t+1+k. The last beat is at t+`OUT_LANES`.
- `STATE_READY` returns to 1 in the cycle after the last beat. Minimum spacing is therefore `OUT_LANES`+1 cycles per digest.
- All outputs are registered or decoded from registered state only. There is no combinational path from `DOUT_READY` or `STATE_VALID` to any output.

## Structure
- `sha3_pkg` holds:
  - `LANE_W`=64 and `STATE_W`=1600;
  - the `squeeze_state_t` enum {`IDLE`, `SEND`};
  - a `lane(state, x, y)` extraction function shared with the absorb unit and the round core.
- Single module, no sub-module. The lane select is an indexed part-select on the buffer.

## Test plan
- **Empty-message digest.** Use the SHA3-256("") state, `DOUT_READY`=1.
  - Required `DOUT` sequence: 64'h66d71ebff8c6ffa7, 64'h62d661a05647c151, 64'hfa493be44dff80f5, 64'h4a43f8804b0ad882.
  - `DOUT_LAST` only on beat 4.
  - `STATE_READY` low for exactly 4 cycles.
- **Backpressure.**
  - `STATE_IN` with lane i = i+1.
  - Toggle `DOUT_READY` 1,0,0,1,0,1,1.
  - Required: outputs 1,2,3,4 with no repeats or skips, and `DOUT` stable on every stalled cycle.
- **Capture isolation.**
  - Change `STATE_IN` to all-ones and hold `STATE_VALID`=1 during `SEND`.
  - Required: the captured lanes are still output, and a second capture occurs only after `IDLE` is re-entered.
- **Abort.**
  - Assert `ABORT` during beat 2 with `DOUT_READY`=1.
  - Required: `DOUT_VALID`=0 the next cycle and `STATE_READY`=1.
  - A new state then streams from lane 0.
- **Reset mid-stream.**
  - Pull `RST_N` low between clock edges during lane 2.
  - Required: `DOUT_VALID`, `DOUT_LAST` and `DOUT` go to 0 without waiting for a clock edge, and there is no spurious beat after release.
- **`OUT_LANES`=1 instance.**
  - Required: a single beat with `DOUT_LAST`=1, then `IDLE`.
